// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit accumulation, select/cancel/timeout arbitration,
// and req/ack handshakes to the dispense mechanism and the nickel change hopper.
module vend_controller #(
    parameter int unsigned PRICE      = 50,
    parameter int unsigned MAX_CREDIT = 150,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic       cancel,
    input  logic       vend_done,
    input  logic       chg_ack,
    output logic       coin_accept,
    output logic       coin_reject,
    output logic       sel_nack,
    output logic       vend_req,
    output logic       chg_req,
    output logic [7:0] credit
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

    state_e        state_q, state_d;
    logic [7:0]    credit_q, credit_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          coin_reject_q, coin_reject_d;
    logic          sel_nack_q, sel_nack_d;
    logic          vend_req_q, vend_req_d;
    logic          chg_req_q, chg_req_d;
    logic [8:0]    coin_val;
    logic [8:0]    coin_sum;
    logic          coin_fits;
    logic          any_event;

    always_comb begin
        unique case (coin_type)
            2'b00:   coin_val = 9'd5;
            2'b01:   coin_val = 9'd10;
            2'b10:   coin_val = 9'd25;
            default: coin_val = 9'd100;
        endcase
    end

    // Nine bits wide so an over-ceiling coin can never wrap into range.
    assign coin_sum  = {1'b0, credit_q} + coin_val;
    assign coin_fits = coin_sum <= 9'(MAX_CREDIT);
    assign any_event = coin_valid | sel_valid | cancel;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        tmo_d         = '0;
        coin_reject_d = 1'b0;
        sel_nack_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                sel_nack_d = sel_valid;
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[7:0];
                        state_d  = StCredit;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            StCredit: begin
                if (cancel) begin
                    state_d       = StChange;
                    coin_reject_d = coin_valid;
                end else if (sel_valid && credit_q >= 8'(PRICE)) begin
                    credit_d      = credit_q - 8'(PRICE);
                    state_d       = StVend;
                    coin_reject_d = coin_valid;
                end else begin
                    sel_nack_d = sel_valid;
                    if (coin_valid) begin
                        if (coin_fits) credit_d = coin_sum[7:0];
                        else           coin_reject_d = 1'b1;
                    end
                    // Any front-end activity restarts the idle window.
                    if (!any_event) begin
                        if (tmo_q == CW'(TIMEOUT - 1)) state_d = StChange;
                        else                           tmo_d   = tmo_q + 1'b1;
                    end
                end
            end
            StVend: begin
                coin_reject_d = coin_valid;
                sel_nack_d    = sel_valid;
                if (vend_done) state_d = (credit_q != 8'd0) ? StChange : StIdle;
            end
            default: begin
                coin_reject_d = coin_valid;
                sel_nack_d    = sel_valid;
                if (chg_req_q && chg_ack) credit_d = credit_q - 8'd5;
                if (credit_d == 8'd0) state_d = StIdle;
            end
        endcase
        vend_req_d = (state_d == StVend);
        chg_req_d  = (state_d == StChange) && (credit_d != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            credit_q      <= 8'd0;
            tmo_q         <= '0;
            coin_reject_q <= 1'b0;
            sel_nack_q    <= 1'b0;
            vend_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            tmo_q         <= tmo_d;
            coin_reject_q <= coin_reject_d;
            sel_nack_q    <= sel_nack_d;
            vend_req_q    <= vend_req_d;
            chg_req_q     <= chg_req_d;
        end
    end

    assign coin_accept = (state_q == StIdle) || (state_q == StCredit);
    assign coin_reject = coin_reject_q;
    assign sel_nack    = sel_nack_q;
    assign vend_req    = vend_req_q;
    assign chg_req     = chg_req_q;
    assign credit      = credit_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios followed by random traffic,
// all compared every cycle against a credit/flag reference model.
module tb_vend_controller;

    localparam int PRICE      = 50;
    localparam int MAX_CREDIT = 150;
    localparam int TIMEOUT    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       sel_valid = 1'b0;
    logic       cancel = 1'b0;
    logic       vend_done = 1'b0;
    logic       chg_ack = 1'b0;
    logic       coin_accept, coin_reject, sel_nack, vend_req, chg_req;
    logic [7:0] credit;

    int checks = 0;
    int failures = 0;

    // Reference model: credit plus "dispensing"/"refunding" flags and an idle-cycle count.
    int m_credit = 0;
    bit m_vend = 0;
    bit m_chg = 0;
    int m_idle = 0;
    bit m_rej = 0;
    bit m_nack = 0;

    vend_controller #(
        .PRICE(PRICE),
        .MAX_CREDIT(MAX_CREDIT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .coin_valid(coin_valid),
        .coin_type(coin_type),
        .sel_valid(sel_valid),
        .cancel(cancel),
        .vend_done(vend_done),
        .chg_ack(chg_ack),
        .coin_accept(coin_accept),
        .coin_reject(coin_reject),
        .sel_nack(sel_nack),
        .vend_req(vend_req),
        .chg_req(chg_req),
        .credit(credit)
    );

    always #5 clk = ~clk;

    function automatic int cval(input logic [1:0] ct);
        int vals [4] = '{5, 10, 25, 100};
        return vals[ct];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_coin(input logic [1:0] ct);
        if (m_credit + cval(ct) <= MAX_CREDIT) m_credit += cval(ct);
        else m_rej = 1;
    endtask

    task automatic model_step(input logic r, input logic cv, input logic [1:0] ct,
                              input logic sv, input logic cn, input logic vd, input logic ca);
        m_rej  = 0;
        m_nack = 0;
        if (r) begin
            m_credit = 0; m_vend = 0; m_chg = 0; m_idle = 0;
        end else if (m_vend) begin
            m_rej = cv; m_nack = sv; m_idle = 0;
            if (vd) begin
                m_vend = 0;
                m_chg  = (m_credit > 0);
            end
        end else if (m_chg) begin
            m_rej = cv; m_nack = sv; m_idle = 0;
            if (ca && m_credit > 0) m_credit -= 5;
            if (m_credit == 0) m_chg = 0;
        end else if (m_credit == 0) begin
            m_nack = sv; m_idle = 0;
            if (cv) add_coin(ct);
        end else if (cn) begin
            m_chg = 1; m_rej = cv; m_idle = 0;
        end else if (sv && m_credit >= PRICE) begin
            m_credit -= PRICE; m_vend = 1; m_rej = cv; m_idle = 0;
        end else begin
            m_nack = sv;
            if (cv) add_coin(ct);
            if (cv || sv) m_idle = 0;
            else if (m_idle == TIMEOUT - 1) begin
                m_chg = 1; m_idle = 0;
            end else m_idle++;
        end
    endtask

    task automatic cyc(input logic r, input logic cv, input logic [1:0] ct, input logic sv,
                       input logic cn, input logic vd, input logic ca);
        @(negedge clk);
        rst = r; coin_valid = cv; coin_type = ct; sel_valid = sv;
        cancel = cn; vend_done = vd; chg_ack = ca;
        @(posedge clk);
        #1;
        model_step(r, cv, ct, sv, cn, vd, ca);
        check("credit", credit, m_credit);
        check("vend_req", vend_req, m_vend);
        check("chg_req", chg_req, (m_chg && m_credit > 0));
        check("coin_reject", coin_reject, m_rej);
        check("sel_nack", sel_nack, m_nack);
        check("coin_accept", coin_accept, !(m_vend || m_chg));
    endtask

    task automatic idle();
        cyc(0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic coin(input logic [1:0] ct);
        cyc(0, 1, ct, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        // Reset
        cyc(1, 0, 2'b00, 0, 0, 0, 0);
        check("reset_credit", credit, 0);
        check("reset_accept", coin_accept, 1);

        // 25 + 25, select, dispense, back to idle with no change
        coin(2'b10);
        check("credit_25", credit, 25);
        coin(2'b10);
        check("credit_50", credit, 50);
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        check("vend_req_rise", vend_req, 1);
        check("vend_credit_0", credit, 0);
        idle();
        cyc(0, 0, 2'b00, 0, 0, 1, 0);
        check("vend_req_fall", vend_req, 0);
        check("no_change", chg_req, 0);

        // 100, select, then 10 nickels of change
        coin(2'b11);
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        check("vend_credit_50", credit, 50);
        cyc(0, 0, 2'b00, 0, 0, 1, 0);
        check("chg_req_rise", chg_req, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 2'b00, 0, 0, 0, 1);
        check("change_done_credit", credit, 0);
        check("change_done_chg_req", chg_req, 0);
        check("change_done_idle", coin_accept, 1);

        // Overflow at the ceiling
        coin(2'b11); coin(2'b10); coin(2'b10);
        check("credit_150", credit, 150);
        coin(2'b00);
        check("overflow_reject", coin_reject, 1);
        check("overflow_credit", credit, 150);
        cyc(0, 0, 2'b00, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 2'b00, 0, 0, 0, 1);
        check("overflow_refund", credit, 0);

        // Short credit: nack, then cancel returns two nickels
        coin(2'b01);
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        check("short_nack", sel_nack, 1);
        check("short_credit", credit, 10);
        cyc(0, 0, 2'b00, 0, 1, 0, 0);
        check("cancel_chg_req", chg_req, 1);
        cyc(0, 0, 2'b00, 0, 0, 0, 1);
        cyc(0, 0, 2'b00, 0, 0, 0, 1);
        check("cancel_refund", credit, 0);
        check("cancel_idle", coin_accept, 1);

        // Select and coin together at exact price
        coin(2'b10); coin(2'b10);
        cyc(0, 1, 2'b10, 1, 0, 0, 0);
        check("same_cycle_vend", vend_req, 1);
        check("same_cycle_reject", coin_reject, 1);
        cyc(0, 0, 2'b00, 0, 0, 1, 0);

        // Cancel beats select
        coin(2'b10);
        cyc(0, 0, 2'b00, 1, 1, 0, 0);
        check("cancel_over_sel_vend", vend_req, 0);
        check("cancel_over_sel_chg", chg_req, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 2'b00, 0, 0, 0, 1);

        // Timeout: change requested TIMEOUT cycles after entering credit
        coin(2'b00);
        n = 0;
        while (n < 20 && chg_req !== 1'b1) begin
            idle();
            n++;
        end
        check("timeout_cycles", n, TIMEOUT);
        cyc(0, 0, 2'b00, 0, 0, 0, 1);

        // Reset in the middle of a vend
        coin(2'b11);
        cyc(0, 0, 2'b00, 1, 0, 0, 0);
        check("pre_rst_vend", vend_req, 1);
        cyc(1, 0, 2'b00, 0, 0, 0, 0);
        check("rst_vend_req", vend_req, 0);
        check("rst_credit", credit, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(999) < 5),
                ($urandom_range(99) < 20),
                2'($urandom_range(3)),
                ($urandom_range(99) < 10),
                ($urandom_range(99) < 3),
                ($urandom_range(99) < 20),
                ($urandom_range(99) < 50));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the vending machine. Accumulates coin credit, arbitrates among coin insertion, product selection, cancel and inactivity timeout, and drives the dispense mechanism and a nickel change hopper through req/ack handshakes. Sits between the coin/keypad front end and the dispense and change actuators, and replaces fixed-price coin counting with credit-based sequencing.

## Interface
- PRICE, 50: product price in cents; multiple of 5, at most MAX_CREDIT.
- MAX_CREDIT, 150: credit ceiling in cents; multiple of 5, at most 255.
- TIMEOUT, 1000: idle cycles in CREDIT before an automatic refund; at least 2.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle pulse; a coin is present.
- coin_type  in  2  coin value: 00=5, 01=10, 10=25, 11=100 cents; valid only with coin_valid.
- sel_valid  in  1  one-cycle product-select pulse.
- cancel  in  1  one-cycle refund request.
- vend_done  in  1  the dispense mechanism has finished.
- chg_ack  in  1  the hopper has ejected one nickel.
- coin_accept  out  1  combinational; 1 in IDLE and CREDIT.
- coin_reject  out  1  registered one-cycle pulse; the coin is returned and not credited.
- sel_nack  out  1  registered one-cycle pulse; the selection is refused.
- vend_req  out  1  registered level; held high for the whole of VEND.
- chg_req  out  1  registered level; high in CHANGE while credit is above 0.
- credit  out  8  registered current credit in cents.

## Operation
- States:
  - IDLE: credit is 0.
  - CREDIT: credit is above 0.
  - VEND
  - CHANGE
- IDLE/CREDIT coin handling: value v is taken from coin_type.
  - If credit+v ≤ MAX_CREDIT: credit += v. IDLE goes to CREDIT.
  - Otherwise: coin_reject pulses and credit is unchanged.
  - The addition is computed 9 bits wide, so there is no wrap.
- Coin while coin_accept=0 (VEND/CHANGE): coin_reject pulses and credit is unchanged.
- sel_valid in IDLE, VEND or CHANGE: sel_nack pulses; no other effect.
- CREDIT, same-cycle priority is cancel > sel_valid > coin:
  - cancel: go to CHANGE. A coin in the same cycle is rejected and a sel_valid is ignored.
  - sel_valid with credit ≥ PRICE: credit -= PRICE on the same edge, then go to VEND. A coin in the same cycle is rejected.
  - sel_valid with credit < PRICE: sel_nack pulses. A coin in the same cycle is still evaluated against the pre-coin credit and accepted or rejected as normal.
- cancel in IDLE, VEND or CHANGE: ignored.
- Timeout:
  - The counter clears on entry to CREDIT and on any coin, sel_valid or cancel.
  - It otherwise increments each CREDIT cycle.
  - On reaching TIMEOUT-1 the next state is CHANGE.
- VEND:
  - vend_req=1.
  - On vend_done=1: go to CHANGE if credit > 0, otherwise go to IDLE.
  - vend_done outside VEND is ignored.
- CHANGE:
  - chg_req=1 while credit > 0.
  - Each cycle with chg_req&&chg_ack: credit -= 5.
  - When credit becomes 0, chg_req drops on the same edge and the state goes to IDLE.
  - chg_ack while chg_req=0 is ignored.
- Credit is always a multiple of 5, so change never underflows.

## Timing
- Reset values:
  - state IDLE
  - credit 0
  - vend_req 0
  - chg_req 0
  - coin_reject 0
  - sel_nack 0
  - coin_accept 1
  - timeout counter 0
- rst asserted mid-transaction drops everything to the reset values on the next edge; the held credit is forfeited.
- Latencies:
  - Coin to credit update: 1 cycle.
  - coin_reject and sel_nack: 1 cycle after the input sample.
  - sel_valid to vend_req high: 1 cycle.
  - vend_done to vend_req low: 1 cycle.
- vend_req and chg_req are pure levels. Each hopper ack consumes one nickel; back-to-back acks give one nickel per cycle.
- Timeout: with no events, CHANGE is entered exactly TIMEOUT cycles after entering CREDIT.

## Test plan
- Reset, then a 25 coin, then a second 25 coin, then sel_valid:
  - credit goes 25 then 50.
  - vend_req rises 1 cycle after sel_valid and credit=0.
  - vend_done returns the block to IDLE with no chg_req.
- Coin 100 then sel_valid:
  - credit=50 and vend_req rises.
  - After vend_done, chg_req is high; chg_ack held high for 10 cycles gives credit 50→0 and then IDLE.
- Overflow:
  - Coin 100, coin 25, coin 25 gives credit 150.
  - A further coin 5 pulses coin_reject and credit stays 150.
- Coin 10 then sel_valid: sel_nack pulses and the block stays in CREDIT with credit 10. Then cancel: chg_req with acks returns 2 nickels and the block goes to IDLE.
- Same-cycle events:
  - credit=50 with sel_valid and coin 25 together: vend, and coin_reject pulses.
  - credit=25 with cancel and sel_valid together: CHANGE, and no vend_req.
- Timeout and reset:
  - With TIMEOUT=8, coin 5 then idle: chg_req rises 8 cycles after entry to CREDIT.
  - rst during VEND: vend_req=0 and credit=0 on the next edge.
